calc_display_driver: RTL and testbench



---
 rtl/calc_disp_pkg.sv | 25 ++
 rtl/calc_display_driver_if.sv | 24 ++
 rtl/calc_bin2bcd.sv | 88 ++++++++
 rtl/calc_display_driver.sv | 123 ++++++++++++
 tb/tb_calc_display_driver.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_disp_pkg.sv
// rtl/calc_disp_pkg.sv - shared types and glyph constants for the calculator display driver
package calc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_POS = 6;
    localparam int NUM_BCD = 5;

    // Segment order is {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/calc_display_driver_if.sv
// rtl/calc_display_driver_if.sv - result/status and display signals of the display driver
interface calc_display_driver_if;
    import calc_disp_pkg::*;

    logic signed [15:0]        value_in;
    logic                      load;
    logic                      busy;
    logic                      valid;
    logic                      neg;
    logic [4*NUM_BCD-1:0]      bcd;
    logic [6:0]                seg;
    logic [NUM_POS-1:0]        an;

    modport master (
        output value_in, load,
        input  busy, valid, neg, bcd, seg, an
    );

    modport slave (
        input  value_in, load,
        output busy, valid, neg, bcd, seg, an
    );

endinterface

// File: rtl/calc_bin2bcd.sv
// rtl/calc_bin2bcd.sv - sequential double-dabble of a signed 16-bit value into sign + 5 BCD digits
module calc_bin2bcd
    import calc_disp_pkg::*;
(
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  start,
    input  logic signed [15:0]    value_in,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*NUM_BCD-1:0]  bcd
);

    state_t               state;
    state_t               next_state;
    logic [3:0]           cnt;
    logic [15:0]          mag;
    logic [4*NUM_BCD-1:0] bcd_work;
    logic [4*NUM_BCD-1:0] bcd_adj;
    logic                 sign;
    logic [15:0]          vin_u;

    assign vin_u = value_in;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == 4'd15) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == DONE);
        done = (state == DONE);
    end

    // Add-3 correction applied before each shift keeps every nibble a valid decimal digit
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < NUM_BCD; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt      <= '0;
            mag      <= '0;
            bcd_work <= '0;
            sign     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Two's-complement negate; -32768 maps to 0x8000 unsigned, which is exact
                        mag      <= vin_u[15] ? (~vin_u + 16'd1) : vin_u;
                        sign     <= vin_u[15];
                        bcd_work <= '0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_work, mag} <= {bcd_adj[4*NUM_BCD-2:0], mag, 1'b0};
                    cnt             <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign neg = sign;
    assign bcd = bcd_work;

endmodule

// File: rtl/calc_display_driver.sv
// rtl/calc_display_driver.sv - load edge detect, result hold registers and multiplexed 7-segment scan
module calc_display_driver
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  nRST,
    calc_display_driver_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic                 load_q;
    logic                 start;
    logic                 conv_busy;
    logic                 conv_done;
    logic                 conv_neg;
    logic [4*NUM_BCD-1:0] conv_bcd;

    logic                 valid_r;
    logic                 neg_r;
    logic [4*NUM_BCD-1:0] bcd_r;

    logic [CW-1:0]        ref_cnt;
    logic [2:0]           idx;
    logic [2:0]           msd;
    logic [3:0]           pos_digit;
    logic [6:0]           seg_next;
    logic [NUM_POS-1:0]   an_next;
    logic [6:0]           seg_r;
    logic [NUM_POS-1:0]   an_r;

    assign start = bus.load & ~load_q;

    calc_bin2bcd u_bin2bcd (
        .clk      (clk),
        .nRST     (nRST),
        .start    (start),
        .value_in (bus.value_in),
        .busy     (conv_busy),
        .done     (conv_done),
        .neg      (conv_neg),
        .bcd      (conv_bcd)
    );

    // Displayed value only changes on completion, never mid-conversion
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            load_q  <= 1'b0;
            valid_r <= 1'b0;
            neg_r   <= 1'b0;
            bcd_r   <= '0;
        end else begin
            load_q <= bus.load;
            if (conv_done) begin
                valid_r <= 1'b1;
                neg_r   <= conv_neg;
                bcd_r   <= conv_bcd;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= (idx == 3'(NUM_POS - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            ref_cnt <= ref_cnt + CW'(1);
        end
    end

    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < NUM_BCD; i++) begin
            if (bcd_r[4*i +: 4] != 4'd0) msd = 3'(i);
        end
    end

    always_comb begin
        case (idx)
            3'd0:    pos_digit = bcd_r[3:0];
            3'd1:    pos_digit = bcd_r[7:4];
            3'd2:    pos_digit = bcd_r[11:8];
            3'd3:    pos_digit = bcd_r[15:12];
            3'd4:    pos_digit = bcd_r[19:16];
            default: pos_digit = 4'd0;
        endcase
    end

    // Leading-zero blanking; the minus sits just left of the most significant digit
    always_comb begin
        seg_next = SEG_BLANK;
        if (idx <= msd) begin
            seg_next = digit_glyph(pos_digit);
        end else if ((idx == msd + 3'd1) && neg_r) begin
            seg_next = SEG_MINUS;
        end
        an_next = valid_r ? (NUM_POS'(1) << idx) : '0;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            seg_r <= SEG_BLANK;
            an_r  <= '0;
        end else begin
            seg_r <= valid_r ? seg_next : SEG_BLANK;
            an_r  <= an_next;
        end
    end

    assign bus.busy  = conv_busy;
    assign bus.valid = valid_r;
    assign bus.neg   = neg_r;
    assign bus.bcd   = bcd_r;
    assign bus.seg   = (SEG_ACTIVE_LOW != 0) ? ~seg_r : seg_r;
    assign bus.an    = (SEG_ACTIVE_LOW != 0) ? ~an_r  : an_r;

endmodule

// File: tb/tb_calc_display_driver.sv
// tb/tb_calc_display_driver.sv - randomized self-checking bench for calc_display_driver
module tb_calc_display_driver;

    logic clk;
    logic nRST;
    int   checks;
    int   failures;
    logic [19:0] prev_exp;

    calc_display_driver_if bus ();

    calc_display_driver #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] model_bcd(input int v);
        int m;
        logic [19:0] r;
        m = (v < 0) ? -v : v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int pos);
        logic [6:0] g [10];
        int m, nd, t, d;
        g = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        m = (v < 0) ? -v : v;
        nd = 1;
        t = m / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        if (pos < nd) begin
            d = m;
            for (int i = 0; i < pos; i++) d = d / 10;
            return g[d % 10];
        end
        if (pos == nd && v < 0) return 7'h40;
        return 7'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise load with value v, keep it high for hold cycles, count busy cycles in a 40+ cycle window
    task automatic run_conv(input int v, input int hold, output int nbusy);
        logic partial_bad;
        logic [19:0] seen;
        partial_bad = 1'b0;
        seen = '0;
        bus.value_in = 16'(v);
        bus.load = 1'b1;
        nbusy = 0;
        for (int c = 0; c < hold || c < 40; c++) begin
            tick();
            if (c + 1 >= hold) bus.load = 1'b0;
            if (bus.busy === 1'b1) begin
                nbusy++;
                if (bus.bcd !== prev_exp) begin
                    partial_bad = 1'b1;
                    seen = bus.bcd;
                end
            end
        end
        checks++;
        if (partial_bad) begin
            failures++;
            $display("FAIL partial_bcd v=%0d got=%h want=%h", v, seen, prev_exp);
        end
        prev_exp = model_bcd(v);
    endtask

    task automatic check_result(input string name, input int v, input int nbusy);
        checks++;
        if (nbusy !== 17) begin
            failures++;
            $display("FAIL %s_busy_len got=%0d want=17", name, nbusy);
        end
        checks++;
        if (bus.bcd !== model_bcd(v)) begin
            failures++;
            $display("FAIL %s_bcd got=%h want=%h", name, bus.bcd, model_bcd(v));
        end
        checks++;
        if (bus.neg !== (v < 0)) begin
            failures++;
            $display("FAIL %s_neg got=%b want=%b", name, bus.neg, (v < 0));
        end
        checks++;
        if (bus.valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid got=%b want=1", name, bus.valid);
        end
    endtask

    task automatic check_scan(input int v);
        logic [5:0] last;
        logic [6:0] bad_seg;
        logic       seg_ok;
        int guard, p, len;
        last = bus.an;
        guard = 0;
        while (bus.an == last && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            failures++;
            $display("FAIL scan_sync v=%0d an stuck at %b", v, bus.an);
            return;
        end
        p = -1;
        for (int i = 0; i < 6; i++) if (bus.an == 6'(1 << i)) p = i;
        checks++;
        if (p < 0) begin
            failures++;
            $display("FAIL scan_onehot v=%0d got=%b want=one-hot", v, bus.an);
            return;
        end
        for (int r = 0; r < 6; r++) begin
            len = 0;
            last = bus.an;
            seg_ok = 1'b1;
            bad_seg = '0;
            while (bus.an == last && len < 20) begin
                if (bus.seg !== model_seg(v, p)) begin
                    seg_ok = 1'b0;
                    bad_seg = bus.seg;
                end
                len++;
                tick();
            end
            checks++;
            if (last !== 6'(1 << p)) begin
                failures++;
                $display("FAIL scan_an v=%0d got=%b want=%b", v, last, 6'(1 << p));
            end
            checks++;
            if (!seg_ok) begin
                failures++;
                $display("FAIL scan_seg v=%0d pos=%0d got=%h want=%h", v, p, bad_seg, model_seg(v, p));
            end
            checks++;
            if (len !== 4) begin
                failures++;
                $display("FAIL scan_hold v=%0d pos=%0d got=%0d want=4", v, p, len);
            end
            p = (p + 1) % 6;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.load = 1'b0;
        bus.value_in = '0;
        prev_exp = '0;
        repeat (3) tick();
        checks++;
        if (bus.an !== 6'h00 || bus.seg !== 7'h00) begin
            failures++;
            $display("FAIL reset_display an=%b seg=%h want an=0 seg=00", bus.an, bus.seg);
        end
        nRST = 1'b1;
        repeat (10) tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_flags valid=%b busy=%b want 0 0", bus.valid, bus.busy);
        end
        checks++;
        if (bus.an !== 6'h00 || bus.seg !== 7'h00) begin
            failures++;
            $display("FAIL idle_display an=%b seg=%h want an=0 seg=00", bus.an, bus.seg);
        end
        checks++;
        if (bus.bcd !== 20'h0 || bus.neg !== 1'b0) begin
            failures++;
            $display("FAIL idle_value bcd=%h neg=%b want 0 0", bus.bcd, bus.neg);
        end
    endtask

    task automatic test_basic();
        int nb;
        run_conv(199, 1, nb);
        check_result("v199", 199, nb);
        check_scan(199);
    endtask

    task automatic test_held_load();
        int nb;
        run_conv(-7, 100, nb);
        check_result("neg7_held", -7, nb);
        check_scan(-7);
    endtask

    task automatic test_extremes();
        int nb;
        run_conv(-32768, 1, nb);
        check_result("min", -32768, nb);
        check_scan(-32768);
        run_conv(32767, 1, nb);
        check_result("max", 32767, nb);
    endtask

    task automatic test_zero_ignore();
        int nb;
        bus.value_in = 16'd0;
        bus.load = 1'b1;
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) bus.load = 1'b0;
            if (c == 4) begin
                bus.value_in = 16'd1234;
                bus.load = 1'b1;
            end
            if (bus.busy === 1'b1) nb++;
        end
        bus.load = 1'b0;
        prev_exp = model_bcd(0);
        check_result("zero_ignore", 0, nb);
        check_scan(0);
    endtask

    task automatic test_reset_mid();
        int nb;
        bus.value_in = 16'd4321;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (8) tick();
        nRST = 1'b0;
        #1;
        checks++;
        if (bus.valid !== 1'b0 || bus.bcd !== 20'h0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset valid=%b bcd=%h busy=%b want 0 0 0", bus.valid, bus.bcd, bus.busy);
        end
        checks++;
        if (bus.an !== 6'h00 || bus.seg !== 7'h00) begin
            failures++;
            $display("FAIL midreset_display an=%b seg=%h want 0 00", bus.an, bus.seg);
        end
        tick();
        nRST = 1'b1;
        prev_exp = '0;
        repeat (5) tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.bcd !== 20'h0) begin
            failures++;
            $display("FAIL midreset_after valid=%b bcd=%h want 0 0", bus.valid, bus.bcd);
        end
        run_conv(102, 1, nb);
        check_result("after_reset", 102, nb);
    endtask

    task automatic test_random();
        int nb, v;
        for (int k = 0; k < 8; k++) begin
            v = int'($signed(16'($urandom)));
            run_conv(v, 1 + int'($urandom_range(0, 30)), nb);
            check_result("random", v, nb);
            if (k < 3) check_scan(v);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_held_load();
        test_extremes();
        test_zero_ignore();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
